imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 34 +++
 rtl/word_packer.sv | 56 +++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   HDR_BYTES  : length of the word-count header in bytes
//   WORD_BYTES : bytes per instruction word
//   CNT_W      : width of the byte-within-word counter
//   LEN_W      : width of the word count / word index
//   loader_state_e : loader FSM states
//   wordAdr()  : byte address of a word index relative to a base address
// ----------------------------------------------------------------------------
package loader_pkg;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = $clog2(WORD_BYTES);
   localparam int LEN_W      = 8 * HDR_BYTES;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      DONE,
      ERR
   } loader_state_e;

   // Word index to byte address; the stride is the word size in bytes.
   function automatic logic [31:0] wordAdr(input logic [31:0] base,
                                           input logic [LEN_W-1:0] idx);
      return base + (32'(idx) * 32'(WORD_BYTES));
   endfunction

endpackage

// File: rtl/word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
// Collects bytes into a little-endian word: the first byte pushed ends up in
// bits [7:0], the last in the top byte.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   clr      : synchronous clear of counter and word (new load)
//   push     : byte_in is consumed this cycle
//   byte_in  : incoming byte
//   word_out : assembled word (complete the cycle after the last push)
//   full     : the current push (if any) completes the word
// ----------------------------------------------------------------------------
module word_packer
   import loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    push,
   input  logic [7:0]              byte_in,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    full
);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [8*WORD_BYTES-1:0] sr_q,  sr_d;

   // Bytes enter at the top and shift down, so after a full word the oldest
   // byte sits in the lowest lane. The counter wraps on its own width.
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (clr) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (push) begin
         sr_d  = {byte_in, sr_q[8*WORD_BYTES-1:8]};
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter and shift register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

   assign word_out = sr_q;
   assign full     = (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (2-byte little-endian word count, then the words
// little-endian) and writes the words into instruction memory starting at
// BASE_ADR while holding the CPU. Counts above DEPTH_WORDS are rejected.
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle load request (honoured in IDLE, DONE, ERR)
//   s_valid    : byte stream valid
//   s_data     : byte stream data
//   s_ready    : a byte is accepted when s_valid && s_ready
//   mem_we     : one-cycle write strobe per word
//   mem_adr    : word-aligned byte address, held between writes
//   mem_wdata  : word to write, held between writes
//   cpu_hold   : keep the CPU frozen while loading
//   busy       : load in progress
//   done / err : load complete / load rejected, sticky until start or rst
// ----------------------------------------------------------------------------
module imem_loader
   import loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   loader_state_e     state_q, state_d;
   logic [LEN_W-1:0]  n_q, n_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       wdataHold_q, wdataHold_d;

   logic              accept;
   logic              packerClr;
   logic              packerPush;
   logic              packerFull;
   logic [31:0]       packerWord;
   logic [LEN_W-1:0]  nFull;
   logic [LEN_W-1:0]  idxNext;

   word_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (packerClr),
      .push     (packerPush),
      .byte_in  (s_data),
      .word_out (packerWord),
      .full     (packerFull)
   );

   assign accept     = s_valid && s_ready;
   assign nFull      = {s_data, n_q[7:0]};
   assign idxNext    = idx_q + LEN_W'(1);
   assign packerPush = accept && (state_q == DATA);

   // Output decode from the current state. The write data is shown live from
   // the packer during WRITE and from the hold register otherwise, so the bus
   // only changes in WRITE.
   always_comb begin
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = wdataHold_q;
      unique case (state_q)
         HDR0, HDR1, DATA: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = packerWord;
         end
         DONE:    done = 1'b1;
         ERR:     err  = 1'b1;
         default: ;
      endcase
   end

   assign cpu_hold = busy;
   assign mem_adr  = adr_q;

   // Next-state logic. The address is registered on the cycle the last byte
   // of a word arrives so it is already valid when WRITE begins. The count
   // check is done on the complete header value, so N==0 finishes at once.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      idx_d       = idx_q;
      adr_d       = adr_q;
      wdataHold_d = wdataHold_q;
      packerClr   = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d   = HDR0;
               n_d       = '0;
               idx_d     = '0;
               packerClr = 1'b1;
            end
         end
         HDR0: begin
            if (accept) begin
               n_d     = {n_q[LEN_W-1:8], s_data};
               state_d = HDR1;
            end
         end
         HDR1: begin
            if (accept) begin
               n_d = nFull;
               if (nFull == '0) begin
                  state_d = DONE;
               end else if (32'(nFull) > $unsigned(DEPTH_WORDS)) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept && packerFull) begin
               state_d = WRITE;
               adr_d   = wordAdr(BASE_ADR, idx_q);
            end
         end
         WRITE: begin
            wdataHold_d = packerWord;
            idx_d       = idxNext;
            state_d     = (idxNext == n_q) ? DONE : DATA;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset returns everything to the idle view.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         idx_q       <= '0;
         adr_q       <= BASE_ADR;
         wdataHold_q <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         adr_q       <= adr_d;
         wdataHold_q <= wdataHold_d;
      end
   end

endmodule
